// File: rtl/jtag_cmd_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : jtag_cmd_sequencer
// Description : Command FSM behind the JTAG-UART byte decoder. Acks decoded
//               instructions and data bytes, assembles multi-byte parameters
//               into config registers, pulses triggers and streams image
//               bytes to the SDRAM writer with a valid/ready handshake.
//               Optional build macro WATCHDOG_EN adds an inter-byte timeout
//               (TIMEOUT_CYC) in collect and transfer states.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC  = 50_000_000,
  parameter int unsigned FRAME_ID_MAX = 63
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iNEW_INSTR,
  input  logic [6:0]  iINSTR,
  input  logic        iNEW_DATA,
  input  logic [7:0]  iDATA,
  output logic        oACK_INSTR,
  output logic        oACK_DATA,
  output logic        oIDLE_TO_TAKE_CMD,
  output logic [15:0] oOFFSET_H,
  output logic [15:0] oOFFSET_V,
  output logic [7:0]  oCYC_DISPLAY,
  output logic [7:0]  oNUM_FRAMES,
  output logic [15:0] oGALVO_NUM_POS,
  output logic [5:0]  oSTATIC_ID,
  output logic        oTRIG_SEQ,
  output logic        oTRIG_GALVO,
  output logic        oXFER_START,
  output logic        oXFER_SINGLE,
  output logic [7:0]  oXFER_ARG,
  output logic [7:0]  oPIX_DATA,
  output logic        oPIX_VALID,
  input  logic        iPIX_READY,
  input  logic        iXFER_DONE,
  output logic        oERROR
);

  // Instruction codes, mirroring jtag_decoder_param.h
  localparam logic [6:0] ST_IDLE              = 7'd0;
  localparam logic [6:0] ST_OFFSET_H          = 7'd1;
  localparam logic [6:0] ST_OFFSET_V          = 7'd2;
  localparam logic [6:0] ST_CYC_DISPLAY       = 7'd3;
  localparam logic [6:0] ST_NUM_FRAMES        = 7'd4;
  localparam logic [6:0] ST_GALVO_NUM_POS     = 7'd5;
  localparam logic [6:0] ST_STATIC_DISPLAY    = 7'd6;
  localparam logic [6:0] ST_TRIG_SEQ          = 7'd7;
  localparam logic [6:0] ST_TRIG_GALVO        = 7'd8;
  localparam logic [6:0] ST_UPDATE_RAM        = 7'd9;
  localparam logic [6:0] ST_UPDATE_RAM_SINGLE = 7'd10;
  localparam logic [6:0] ST_ERROR             = 7'd11;
  localparam logic [6:0] INSTRUCTION_ACK      = 7'h7F;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ERROR     = 3'd1,
    S_COLLECT   = 3'd2,   // gathering parameter bytes for cmd_q
    S_COMMIT    = 3'd3,   // one cycle after last byte ack: publish register
    S_TRIG      = 3'd4,   // trigger pulse cycle
    S_XFER_ARG  = 3'd5,   // waiting for frame count / frame id byte
    S_XFER_BUSY = 3'd6    // streaming pixel bytes
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cmd_q, cmd_d;
  logic        cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        ack_instr_q, ack_instr_d;
  logic        ack_data_q, ack_data_d;
  logic        idle_take_q;
  logic        error_q;
  logic [15:0] off_h_q, off_h_d;
  logic [15:0] off_v_q, off_v_d;
  logic [7:0]  cyc_q, cyc_d;
  logic [7:0]  nfr_q, nfr_d;
  logic [15:0] galvo_q, galvo_d;
  logic [5:0]  static_q, static_d;
  logic        trig_seq_q, trig_seq_d;
  logic        trig_galvo_q, trig_galvo_d;
  logic        xstart_q, xstart_d;
  logic        xsingle_q, xsingle_d;
  logic [7:0]  xarg_q, xarg_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;

  // The decoder drops its flag one cycle after seeing our ack, so both flags
  // are stale while an ack pulse is on the wire.
  logic blank;
  logic instr_ok;
  logic data_ok;
  logic two_byte;
  logic last_byte;
  logic id_too_big;

  assign blank      = ack_instr_q | ack_data_q;
  assign instr_ok   = iNEW_INSTR & ~blank;
  assign data_ok    = iNEW_DATA & ~iNEW_INSTR & ~blank;
  assign two_byte   = (cmd_q == ST_OFFSET_H) || (cmd_q == ST_OFFSET_V) ||
                      (cmd_q == ST_GALVO_NUM_POS);
  assign last_byte  = ~two_byte | cnt_q;
  assign id_too_big = ({24'd0, iDATA} > FRAME_ID_MAX);

`ifdef WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_active;
  assign wd_active = (state_q == S_COLLECT) || (state_q == S_XFER_ARG) ||
                     (state_q == S_XFER_BUSY);
`else
  // Without the watchdog TIMEOUT_CYC has no effect; this empty guard only
  // keeps the parameter visible in the default build.
  if (TIMEOUT_CYC == 0) begin : g_no_watchdog
  end
`endif

  // Next-state and next-output computation for the command FSM
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    ack_instr_d  = 1'b0;
    ack_data_d   = 1'b0;
    off_h_d      = off_h_q;
    off_v_d      = off_v_q;
    cyc_d        = cyc_q;
    nfr_d        = nfr_q;
    galvo_d      = galvo_q;
    static_d     = static_q;
    trig_seq_d   = 1'b0;
    trig_galvo_d = 1'b0;
    xstart_d     = 1'b0;
    xsingle_d    = xsingle_q;
    xarg_d       = xarg_q;
    pix_data_d   = pix_data_q;
    pix_valid_d  = pix_valid_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (instr_ok) begin
          ack_instr_d = 1'b1;
          case (iINSTR)
            ST_IDLE:         state_d = S_IDLE;
            INSTRUCTION_ACK: state_d = state_q;
            ST_ERROR:        state_d = S_ERROR;
            ST_OFFSET_H, ST_OFFSET_V, ST_GALVO_NUM_POS,
            ST_CYC_DISPLAY, ST_NUM_FRAMES, ST_STATIC_DISPLAY: begin
              state_d = S_COLLECT;
              cmd_d   = iINSTR;
              cnt_d   = 1'b0;
            end
            ST_TRIG_SEQ: begin
              state_d    = S_TRIG;
              trig_seq_d = 1'b1;
            end
            ST_TRIG_GALVO: begin
              state_d      = S_TRIG;
              trig_galvo_d = 1'b1;
            end
            ST_UPDATE_RAM, ST_UPDATE_RAM_SINGLE: begin
              state_d = S_XFER_ARG;
              cmd_d   = iINSTR;
            end
            default:         state_d = S_ERROR;
          endcase
        end else if (data_ok) begin
          // Stray bytes between commands are consumed and discarded
          ack_data_d = 1'b1;
        end
      end

      S_COLLECT: begin
        if (data_ok) begin
          ack_data_d = 1'b1;
          shift_d    = {shift_q[7:0], iDATA};
          if (!last_byte) begin
            cnt_d = 1'b1;
          end else if ((cmd_q == ST_STATIC_DISPLAY) && id_too_big) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end

      S_COMMIT: begin
        // All bytes are in; publish the whole parameter in one cycle
        case (cmd_q)
          ST_OFFSET_H:       off_h_d  = shift_q;
          ST_OFFSET_V:       off_v_d  = shift_q;
          ST_GALVO_NUM_POS:  galvo_d  = shift_q;
          ST_CYC_DISPLAY:    cyc_d    = shift_q[7:0];
          ST_NUM_FRAMES:     nfr_d    = shift_q[7:0];
          ST_STATIC_DISPLAY: static_d = shift_q[5:0];
          default:           cyc_d    = cyc_q;
        endcase
        state_d = S_IDLE;
      end

      S_TRIG: state_d = S_IDLE;

      S_XFER_ARG: begin
        if (data_ok) begin
          ack_data_d = 1'b1;
          if ((cmd_q == ST_UPDATE_RAM_SINGLE) && id_too_big) begin
            state_d = S_ERROR;
          end else begin
            xarg_d    = iDATA;
            xsingle_d = (cmd_q == ST_UPDATE_RAM_SINGLE);
            xstart_d  = 1'b1;
            state_d   = S_XFER_BUSY;
          end
        end
      end

      S_XFER_BUSY: begin
        if (iXFER_DONE) begin
          // Writer is finished; any byte still offered is dropped unacked
          state_d     = S_IDLE;
          pix_valid_d = 1'b0;
        end else if (!instr_ok) begin
          if (pix_valid_q) begin
            if (iPIX_READY) begin
              ack_data_d  = 1'b1;
              pix_valid_d = 1'b0;
            end
          end else if (data_ok) begin
            pix_data_d  = iDATA;
            pix_valid_d = 1'b1;
          end
        end
      end

      default: state_d = S_ERROR;
    endcase

    // Instructions arriving mid-command: ST_IDLE aborts, INSTRUCTION_ACK is
    // only acknowledged, anything else is a protocol violation.
    if (instr_ok && (state_q == S_COLLECT || state_q == S_XFER_ARG ||
                     (state_q == S_XFER_BUSY && !iXFER_DONE))) begin
      ack_instr_d = 1'b1;
      if (iINSTR == ST_IDLE) begin
        state_d     = S_IDLE;
        pix_valid_d = 1'b0;
      end else if (iINSTR != INSTRUCTION_ACK) begin
        state_d     = S_ERROR;
        pix_valid_d = 1'b0;
      end
    end

`ifdef WATCHDOG_EN
    // Count silent cycles; any ack or state change restarts the count
    wd_d = '0;
    if (wd_active && (state_d == state_q) && !ack_instr_d && !ack_data_d) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        state_d     = S_ERROR;
        pix_valid_d = 1'b0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  // State, config and output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q      <= S_IDLE;
      cmd_q        <= ST_IDLE;
      cnt_q        <= 1'b0;
      shift_q      <= '0;
      ack_instr_q  <= 1'b0;
      ack_data_q   <= 1'b0;
      idle_take_q  <= 1'b1;
      error_q      <= 1'b0;
      off_h_q      <= '0;
      off_v_q      <= '0;
      cyc_q        <= '0;
      nfr_q        <= '0;
      galvo_q      <= '0;
      static_q     <= '0;
      trig_seq_q   <= 1'b0;
      trig_galvo_q <= 1'b0;
      xstart_q     <= 1'b0;
      xsingle_q    <= 1'b0;
      xarg_q       <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
`ifdef WATCHDOG_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      ack_instr_q  <= ack_instr_d;
      ack_data_q   <= ack_data_d;
      idle_take_q  <= (state_d == S_IDLE) || (state_d == S_ERROR);
      error_q      <= (state_d == S_ERROR);
      off_h_q      <= off_h_d;
      off_v_q      <= off_v_d;
      cyc_q        <= cyc_d;
      nfr_q        <= nfr_d;
      galvo_q      <= galvo_d;
      static_q     <= static_d;
      trig_seq_q   <= trig_seq_d;
      trig_galvo_q <= trig_galvo_d;
      xstart_q     <= xstart_d;
      xsingle_q    <= xsingle_d;
      xarg_q       <= xarg_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
`ifdef WATCHDOG_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign oACK_INSTR        = ack_instr_q;
  assign oACK_DATA         = ack_data_q;
  assign oIDLE_TO_TAKE_CMD = idle_take_q;
  assign oERROR            = error_q;
  assign oOFFSET_H         = off_h_q;
  assign oOFFSET_V         = off_v_q;
  assign oCYC_DISPLAY      = cyc_q;
  assign oNUM_FRAMES       = nfr_q;
  assign oGALVO_NUM_POS    = galvo_q;
  assign oSTATIC_ID        = static_q;
  assign oTRIG_SEQ         = trig_seq_q;
  assign oTRIG_GALVO       = trig_galvo_q;
  assign oXFER_START       = xstart_q;
  assign oXFER_SINGLE      = xsingle_q;
  assign oXFER_ARG         = xarg_q;
  assign oPIX_DATA         = pix_data_q;
  assign oPIX_VALID        = pix_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_cmd_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_jtag_cmd_sequencer
// Description : Directed bench for jtag_cmd_sequencer. A small decoder model
//               holds each flag until one cycle after the ack, so exact ack
//               counts also prove the post-ack blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_cmd_sequencer;

  localparam logic [6:0] ST_IDLE              = 7'd0;
  localparam logic [6:0] ST_OFFSET_H          = 7'd1;
  localparam logic [6:0] ST_OFFSET_V          = 7'd2;
  localparam logic [6:0] ST_CYC_DISPLAY       = 7'd3;
  localparam logic [6:0] ST_NUM_FRAMES        = 7'd4;
  localparam logic [6:0] ST_GALVO_NUM_POS     = 7'd5;
  localparam logic [6:0] ST_STATIC_DISPLAY    = 7'd6;
  localparam logic [6:0] ST_TRIG_SEQ          = 7'd7;
  localparam logic [6:0] ST_TRIG_GALVO        = 7'd8;
  localparam logic [6:0] ST_UPDATE_RAM        = 7'd9;
  localparam logic [6:0] ST_UPDATE_RAM_SINGLE = 7'd10;
  localparam logic [6:0] INSTRUCTION_ACK      = 7'h7F;

  logic        iCLK, iRST_N;
  logic        iNEW_INSTR, iNEW_DATA, iPIX_READY, iXFER_DONE;
  logic [6:0]  iINSTR;
  logic [7:0]  iDATA;
  logic        oACK_INSTR, oACK_DATA, oIDLE_TO_TAKE_CMD, oERROR;
  logic [15:0] oOFFSET_H, oOFFSET_V, oGALVO_NUM_POS;
  logic [7:0]  oCYC_DISPLAY, oNUM_FRAMES, oXFER_ARG, oPIX_DATA;
  logic [5:0]  oSTATIC_ID;
  logic        oTRIG_SEQ, oTRIG_GALVO, oXFER_START, oXFER_SINGLE, oPIX_VALID;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ack_i  = 0, n_ack_d = 0, n_tseq = 0, n_tgal = 0, n_xstart = 0;
  logic [7:0] last_arg;
  logic       last_single;
  int base_i, base_d, base_x, wd_cnt;

  jtag_cmd_sequencer #(.TIMEOUT_CYC(100), .FRAME_ID_MAX(63)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iNEW_INSTR(iNEW_INSTR), .iINSTR(iINSTR),
    .iNEW_DATA(iNEW_DATA), .iDATA(iDATA),
    .oACK_INSTR(oACK_INSTR), .oACK_DATA(oACK_DATA),
    .oIDLE_TO_TAKE_CMD(oIDLE_TO_TAKE_CMD),
    .oOFFSET_H(oOFFSET_H), .oOFFSET_V(oOFFSET_V),
    .oCYC_DISPLAY(oCYC_DISPLAY), .oNUM_FRAMES(oNUM_FRAMES),
    .oGALVO_NUM_POS(oGALVO_NUM_POS), .oSTATIC_ID(oSTATIC_ID),
    .oTRIG_SEQ(oTRIG_SEQ), .oTRIG_GALVO(oTRIG_GALVO),
    .oXFER_START(oXFER_START), .oXFER_SINGLE(oXFER_SINGLE),
    .oXFER_ARG(oXFER_ARG), .oPIX_DATA(oPIX_DATA), .oPIX_VALID(oPIX_VALID),
    .iPIX_READY(iPIX_READY), .iXFER_DONE(iXFER_DONE), .oERROR(oERROR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Pulse monitors, sampled on the falling edge
  always @(negedge iCLK) begin
    if (iRST_N) begin
      if (oACK_INSTR) n_ack_i++;
      if (oACK_DATA) n_ack_d++;
      if (oACK_INSTR && oACK_DATA) check("dual_ack", 32'(oACK_DATA), 32'd0);
      if (oTRIG_SEQ) n_tseq++;
      if (oTRIG_GALVO) n_tgal++;
      if (oXFER_START) begin
        n_xstart++;
        last_arg    = oXFER_ARG;
        last_single = oXFER_SINGLE;
      end
    end
  end

  // Bounded wait for an ack; the flag stays up one cycle past the ack
  task automatic wait_ack(input bit is_instr, input int bound, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge iCLK);
      seen = is_instr ? oACK_INSTR : oACK_DATA;
    end
    check(tag, 32'(seen), 32'd1);
    @(negedge iCLK);
  endtask

  task automatic send_instr(input logic [6:0] code);
    iINSTR = code; iNEW_INSTR = 1'b1;
    wait_ack(1'b1, 20, "ack_instr");
    iNEW_INSTR = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    iDATA = b; iNEW_DATA = 1'b1;
    wait_ack(1'b0, 20, "ack_data");
    iNEW_DATA = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    iRST_N = 1'b0; iNEW_INSTR = 1'b0; iNEW_DATA = 1'b0; iINSTR = '0;
    iDATA = '0; iPIX_READY = 1'b0; iXFER_DONE = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    check("rst_idle", 32'(oIDLE_TO_TAKE_CMD), 32'd1);
    check("rst_err",  32'(oERROR), 32'd0);
    check("rst_offh", 32'(oOFFSET_H), 32'd0);
    check("rst_pixv", 32'(oPIX_VALID), 32'd0);

    // OFFSET_H = -200, only visible after the second byte
    base_i = n_ack_i; base_d = n_ack_d;
    send_instr(ST_OFFSET_H);
    check("offh_busy", 32'(oIDLE_TO_TAKE_CMD), 32'd0);
    send_data(8'hFF);
    check("offh_partial", 32'(oOFFSET_H), 32'd0);
    send_data(8'h38);
    check("offh_val", 32'(oOFFSET_H), 32'h0000FF38);
    check("offh_idle", 32'(oIDLE_TO_TAKE_CMD), 32'd1);
    check("offh_nacki", 32'(n_ack_i - base_i), 32'd1);
    check("offh_nackd", 32'(n_ack_d - base_d), 32'd2);

    // Other parameters
    send_instr(ST_OFFSET_V); send_data(8'h00); send_data(8'h64);
    check("offv_val", 32'(oOFFSET_V), 32'd100);
    send_instr(ST_CYC_DISPLAY); send_data(8'h2A);
    check("cyc_val", 32'(oCYC_DISPLAY), 32'h2A);
    send_instr(ST_GALVO_NUM_POS); send_data(8'h12); send_data(8'h34);
    check("galvo_val", 32'(oGALVO_NUM_POS), 32'h1234);
    send_instr(ST_NUM_FRAMES); send_data(8'h07);
    check("nfr_val", 32'(oNUM_FRAMES), 32'd7);

    // Abort before the byte leaves NUM_FRAMES alone
    send_instr(ST_NUM_FRAMES);
    send_instr(ST_IDLE);
    check("abort_nfr", 32'(oNUM_FRAMES), 32'd7);
    check("abort_idle", 32'(oIDLE_TO_TAKE_CMD), 32'd1);
    base_d = n_ack_d;
    send_data(8'h99);
    check("stray_nfr", 32'(oNUM_FRAMES), 32'd7);
    check("stray_ack", 32'(n_ack_d - base_d), 32'd1);

    // Static frame id boundaries
    send_instr(ST_STATIC_DISPLAY); send_data(8'd63);
    check("static_max", 32'(oSTATIC_ID), 32'd63);
    send_instr(ST_STATIC_DISPLAY); send_data(8'd33);
    check("static_val", 32'(oSTATIC_ID), 32'd33);
    send_instr(ST_STATIC_DISPLAY); send_data(8'd64);
    check("static_err", 32'(oERROR), 32'd1);
    check("static_keep", 32'(oSTATIC_ID), 32'd33);
    check("err_take", 32'(oIDLE_TO_TAKE_CMD), 32'd1);
    send_instr(ST_IDLE);
    check("err_clear", 32'(oERROR), 32'd0);

    // Unknown code and INSTRUCTION_ACK
    send_instr(7'h55);
    check("unknown_err", 32'(oERROR), 32'd1);
    send_instr(ST_IDLE);
    send_instr(INSTRUCTION_ACK);
    check("iack_idle", 32'(oIDLE_TO_TAKE_CMD), 32'd1);
    check("iack_err", 32'(oERROR), 32'd0);

    // Triggers: one pulse each
    send_instr(ST_TRIG_SEQ);
    check("tseq_cnt", 32'(n_tseq), 32'd1);
    check("tgal_none", 32'(n_tgal), 32'd0);
    send_instr(ST_TRIG_GALVO);
    check("tgal_cnt", 32'(n_tgal), 32'd1);
    check("trig_idle", 32'(oIDLE_TO_TAKE_CMD), 32'd1);

    // Single frame id out of range, then legal
    base_x = n_xstart;
    send_instr(ST_UPDATE_RAM_SINGLE); send_data(8'd64);
    check("single_err", 32'(oERROR), 32'd1);
    check("single_nostart", 32'(n_xstart - base_x), 32'd0);
    send_instr(ST_IDLE);
    send_instr(ST_UPDATE_RAM_SINGLE); send_data(8'd5);
    check("single_start", 32'(n_xstart - base_x), 32'd1);
    check("single_arg", 32'(last_arg), 32'd5);
    check("single_flag", 32'(last_single), 32'd1);
    check("busy_take", 32'(oIDLE_TO_TAKE_CMD), 32'd0);

    // Pixel held while READY low
    base_d = n_ack_d;
    iDATA = 8'hA5; iNEW_DATA = 1'b1; iPIX_READY = 1'b0;
    repeat (10) @(negedge iCLK);
    check("pix_valid_held", 32'(oPIX_VALID), 32'd1);
    check("pix_data_held", 32'(oPIX_DATA), 32'hA5);
    check("pix_noack", 32'(n_ack_d - base_d), 32'd0);
    iPIX_READY = 1'b1;
    wait_ack(1'b0, 5, "pix_ack");
    iNEW_DATA = 1'b0; iPIX_READY = 1'b0;
    check("pix_oneack", 32'(n_ack_d - base_d), 32'd1);
    check("pix_valid_drop", 32'(oPIX_VALID), 32'd0);

    // Unsent byte dropped by iXFER_DONE
    base_d = n_ack_d;
    iDATA = 8'h77; iNEW_DATA = 1'b1;
    repeat (3) @(negedge iCLK);
    check("pix2_data", 32'(oPIX_DATA), 32'h77);
    iNEW_DATA = 1'b0; iXFER_DONE = 1'b1;
    @(negedge iCLK);
    iXFER_DONE = 1'b0;
    @(negedge iCLK);
    check("done_idle", 32'(oIDLE_TO_TAKE_CMD), 32'd1);
    check("done_pixv", 32'(oPIX_VALID), 32'd0);
    check("done_noack", 32'(n_ack_d - base_d), 32'd0);

    // Multi-frame transfer aborted by ST_IDLE
    send_instr(ST_UPDATE_RAM); send_data(8'd3);
    check("multi_arg", 32'(last_arg), 32'd3);
    check("multi_flag", 32'(last_single), 32'd0);
    iDATA = 8'h11; iNEW_DATA = 1'b1;
    repeat (3) @(negedge iCLK);
    check("multi_pixv", 32'(oPIX_VALID), 32'd1);
    iNEW_DATA = 1'b0;
    send_instr(ST_IDLE);
    check("abort_pixv", 32'(oPIX_VALID), 32'd0);
    check("abort_take", 32'(oIDLE_TO_TAKE_CMD), 32'd1);

    // iXFER_DONE outside a transfer has no effect
    iXFER_DONE = 1'b1;
    @(negedge iCLK);
    iXFER_DONE = 1'b0;
    @(negedge iCLK);
    check("done_ignored", 32'(oERROR), 32'd0);

`ifdef WATCHDOG_EN
    // Silence after one of two GALVO bytes -> ERROR about 100 cycles on
    send_instr(ST_GALVO_NUM_POS); send_data(8'h55);
    wd_cnt = 0;
    while (!oERROR && wd_cnt < 200) begin
      @(negedge iCLK);
      wd_cnt++;
    end
    check("wd_err", 32'(oERROR), 32'd1);
    check("wd_window", 32'(wd_cnt >= 95 && wd_cnt <= 102), 32'd1);
    check("wd_galvo", 32'(oGALVO_NUM_POS), 32'h1234);
    send_instr(ST_IDLE);
`endif

    // Asynchronous reset mid-command
    send_instr(ST_OFFSET_H); send_data(8'h01);
    #2 iRST_N = 1'b0;
    #1;
    check("arst_take", 32'(oIDLE_TO_TAKE_CMD), 32'd1);
    check("arst_offh", 32'(oOFFSET_H), 32'd0);
    check("arst_nfr", 32'(oNUM_FRAMES), 32'd0);
    check("arst_static", 32'(oSTATIC_ID), 32'd0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    check("arst_after", 32'(oIDLE_TO_TAKE_CMD), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
